// File: rtl/period_meter.sv
// Period meter: measures the period and high time of an asynchronous
// periodic input in clk cycles, flags lock when the period stays within
// tolerance of the expected value, and flags a stall when edges stop.
//
// Outputs period/high_time/locked/stall are registered and change only in
// the cycle where meas_valid is high, except that a stall sets stall and
// clears locked on its own. period and high_time hold across stalls.
module period_meter #(
  parameter int EXP_PERIOD = 500,
  parameter int TOL        = 2,
  parameter int LOCK_N     = 4,
  parameter int TIMEOUT    = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sig_in,
  output logic [15:0] period,
  output logic [15:0] high_time,
  output logic        meas_valid,
  output logic        locked,
  output logic        stall
);

  // Tolerance window; the lower bound clamps at zero instead of wrapping.
  localparam logic [31:0] LO_B = (EXP_PERIOD > TOL) ? 32'(EXP_PERIOD - TOL) : 32'd0;
  localparam logic [31:0] HI_B = 32'(EXP_PERIOD + TOL);
  localparam int          MW   = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [MW-1:0] LOCK_M = MW'(LOCK_N);
  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    HIGH       = 2'd1,
    LOW        = 2'd2
  } state_t;

  state_t        state;
  logic          s1, s2, s3;
  logic [15:0]   cnt;
  logic [15:0]   hi_lat;
  logic [MW-1:0] match_cnt;

  logic          rise, fall, timeout, in_tol;
  logic [15:0]   cnt_inc;
  logic [MW-1:0] match_nxt;

  assign rise      = s2 & ~s3;
  assign fall      = ~s2 & s3;
  // cnt saturates at all-ones so a very long gap never wraps to a small value.
  assign cnt_inc   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign timeout   = (cnt >= TO_CNT);
  // cnt is the length of the period being closed when a rise arrives in LOW.
  assign in_tol    = ({16'd0, cnt} >= LO_B) && ({16'd0, cnt} <= HI_B);
  assign match_nxt = (match_cnt >= LOCK_M) ? LOCK_M : match_cnt + 1'b1;

  // Two-flop synchronizer plus one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Measurement FSM with registered outputs; timeout wins over a coinciding edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_FIRST;
      cnt        <= 16'd0;
      hi_lat     <= 16'd0;
      match_cnt  <= '0;
      period     <= 16'd0;
      high_time  <= 16'd0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      stall      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        WAIT_FIRST: begin
          if (rise) begin
            state <= HIGH;
            cnt   <= 16'd1;
          end
        end
        HIGH: begin
          if (timeout) begin
            state     <= WAIT_FIRST;
            cnt       <= 16'd0;
            stall     <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= '0;
          end else begin
            cnt <= cnt_inc;
            if (fall) begin
              state  <= LOW;
              hi_lat <= cnt;
            end
          end
        end
        LOW: begin
          if (timeout) begin
            state     <= WAIT_FIRST;
            cnt       <= 16'd0;
            stall     <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= '0;
          end else if (rise) begin
            state      <= HIGH;
            cnt        <= 16'd1;
            period     <= cnt;
            high_time  <= hi_lat;
            meas_valid <= 1'b1;
            stall      <= 1'b0;
            if (in_tol) begin
              match_cnt <= match_nxt;
              locked    <= (match_nxt == LOCK_M);
            end else begin
              match_cnt <= '0;
              locked    <= 1'b0;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= WAIT_FIRST;
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: sig_in is built from (high, low) pulses; a model
// predicts each measurement from pulse lengths alone.
module tb_period_meter;

  localparam int EXP_PERIOD = 500;
  localparam int TOL        = 2;
  localparam int LOCK_N     = 4;
  localparam int TIMEOUT    = 4095;
  localparam int LO_LIM     = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0;
  localparam int HI_LIM     = EXP_PERIOD + TOL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig_in = 1'b0;
  logic [15:0] period, high_time;
  logic        meas_valid, locked, stall;

  period_meter #(
    .EXP_PERIOD(EXP_PERIOD), .TOL(TOL), .LOCK_N(LOCK_N), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in),
    .period(period), .high_time(high_time),
    .meas_valid(meas_valid), .locked(locked), .stall(stall)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard: {period, high_time} of each period awaiting its meas_valid
  logic [31:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit armed = 0;        // a rise has started a measurement
  int prev_h = 0;       // high length of the pulse in progress
  int prev_tot = 0;     // full length of the pulse in progress
  int m_match = 0;      // consecutive in-tolerance measurements
  bit m_locked = 0;
  logic [15:0] last_p = 16'd0;
  logic [15:0] last_h = 16'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of sig_in, then inspect outputs at the falling edge.
  task automatic step(input logic v);
    logic [31:0] e;
    int ep, eh;
    sig_in = v;
    @(negedge clk);
    if (meas_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_meas_valid", {31'd0, meas_valid}, 32'd0);
      end else begin
        e  = exp_q.pop_front();
        ep = int'(e[31:16]);
        eh = int'(e[15:0]);
        if (ep >= LO_LIM && ep <= HI_LIM) begin
          if (m_match < LOCK_N) m_match++;
          m_locked = (m_match >= LOCK_N);
        end else begin
          m_match  = 0;
          m_locked = 0;
        end
        chk("meas_period", period, ep);
        chk("meas_high_time", high_time, eh);
        chk("meas_locked", locked, m_locked);
        chk("meas_stall_clear", stall, 0);
        last_p = 16'(ep);
        last_h = 16'(eh);
      end
    end else begin
      chk("period_hold", period, last_p);
      chk("high_time_hold", high_time, last_h);
    end
  endtask

  // A rise closes the previous pulse: either a measurement or a timeout.
  task automatic model_rise();
    if (armed) begin
      if (prev_tot >= TIMEOUT) begin
        m_match  = 0;
        m_locked = 0;
        chk("stall_set", stall, 1);
        chk("stall_unlocked", locked, 0);
      end else begin
        exp_q.push_back({16'(prev_tot), 16'(prev_h)});
      end
    end
    armed = 1;
  endtask

  task automatic pulse(input int h, input int l);
    model_rise();
    prev_h   = h;
    prev_tot = h + l;
    for (int i = 0; i < h; i++) step(1'b1);
    for (int i = 0; i < l; i++) step(1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    armed    = 0;
    m_match  = 0;
    m_locked = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_high_time"}, high_time, 0);
    chk({tag, "_meas_valid"}, meas_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_stall"}, stall, 0);
  endtask

  initial begin
    int h, t;
    // reset
    rst = 1'b1;
    last_p = 16'd0;
    last_h = 16'd0;
    repeat (3) step(1'b0);
    check_zero("reset");
    rst = 1'b0;
    model_reset();
    repeat (10) step(1'b0);

    // nominal 500-cycle period, 249 high: lock on the 4th measurement
    repeat (6) pulse(249, 251);
    chk("locked_nominal", locked, 1);

    // one stretched period breaks lock, then relock
    pulse(249, 261);
    repeat (5) pulse(249, 251);

    // tolerance edges: 498 and 502 in, 497 and 503 out
    pulse(249, 249);
    pulse(249, 253);
    pulse(249, 248);
    pulse(249, 254);
    repeat (5) pulse(249, 251);

    // random periods near nominal
    repeat (16) begin
      h = $urandom_range(300, 100);
      t = $urandom_range(506, 494);
      pulse(h, t - h);
    end

    // stall: long low after lock, then recovery
    repeat (5) pulse(249, 251);
    pulse(249, 5000);
    repeat (3) pulse(249, 251);

    // reset asserted in the middle of a high phase
    repeat (5) pulse(249, 251);
    model_rise();
    repeat (100) step(1'b1);
    rst = 1'b1;
    last_p = 16'd0;
    last_h = 16'd0;
    repeat (20) step(1'b1);
    check_zero("midhigh_reset");
    repeat (40) step(1'b0);
    rst = 1'b0;
    model_reset();
    repeat (100) step(1'b0);
    repeat (4) pulse(249, 251);

    // minimum pulse widths and short random pulses
    repeat (20) pulse(2, 2);
    repeat (30) pulse($urandom_range(6, 2), $urandom_range(6, 2));

    // close the last period and flush
    pulse(3, 3);
    repeat (10) step(1'b0);
    chk("pending_meas", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
